sim_lat_mem: RTL and testbench

Parametrised simulation memory model for the traversal datapath's node/bbox fetch path. It accepts tagged index requests from a FIFO-style request stream and looks up a preloadable internal array. Each result is returned on a FIFO-style response stream after a configurable fixed latency. A credit-limited output queue replaces global pipeline stall, so a blocked response stream never freezes in-flight lookups. Out-of-range accesses are flagged, and the block keeps access and error statistics for the bench.

---
 rtl/sim_lat_mem.sv | 148 ++++++++++++++
 tb/tb_sim_lat_mem.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sim_lat_mem.sv
// Fixed-latency lookup memory with tagged requests and a credit-limited
// output queue; never stalls in-flight lookups.
module sim_lat_mem #(
   parameter int IDX_WIDTH  = 10,
   parameter int DEPTH      = 1024,
   parameter int DATA_WIDTH = 64,
   parameter int TAG_WIDTH  = 8,
   parameter int LATENCY    = 4,
   parameter int Q_DEPTH    = LATENCY + 2
) (
   input  logic                              clk,
   input  logic                              arst_n,
   input  logic                              req_empty_n,
   output logic                              req_read,
   input  logic [IDX_WIDTH+TAG_WIDTH-1:0]    req_dout,
   input  logic                              resp_full_n,
   output logic                              resp_write,
   output logic [DATA_WIDTH+TAG_WIDTH:0]     resp_din,
   input  logic                              wr_en,
   input  logic [IDX_WIDTH-1:0]              wr_addr,
   input  logic [DATA_WIDTH-1:0]             wr_data,
   output logic [$clog2(Q_DEPTH+1)-1:0]      outstanding,
   output logic [31:0]                       acc_count,
   output logic [15:0]                       err_count
);
   localparam int W  = 1 + DATA_WIDTH + TAG_WIDTH;
   localparam int OW = $clog2(Q_DEPTH + 1);
   localparam int PW = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   generate
      if (Q_DEPTH < LATENCY + 1) begin : g_chk
         $error("sim_lat_mem: Q_DEPTH must be >= LATENCY+1");
      end
   endgenerate

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [LATENCY-1:0]    vld_q, vld_d;
   logic [W-1:0]          word_q [LATENCY];
   logic [W-1:0]          word_d [LATENCY];
   logic [W-1:0]          fifo_q [Q_DEPTH];
   logic [W-1:0]          fifo_d [Q_DEPTH];
   logic [PW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
   logic [OW-1:0]         fcnt_q, fcnt_d, out_q, out_d;
   logic [31:0]           acc_q, acc_d;
   logic [15:0]           err_q, err_d;

   logic [IDX_WIDTH-1:0]  idx;
   logic [TAG_WIDTH-1:0]  tag;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  in_rng, accept, push, pop, wr_ok;

   assign idx    = req_dout[IDX_WIDTH+TAG_WIDTH-1:TAG_WIDTH];
   assign tag    = req_dout[TAG_WIDTH-1:0];
   assign in_rng = 32'(idx) < 32'(DEPTH);
   assign wr_ok  = arst_n && wr_en && (32'(wr_addr) < 32'(DEPTH));

   assign req_read   = out_q < OW'(Q_DEPTH);
   assign accept     = req_read && req_empty_n;
   assign rd_data    = in_rng ? mem_q[idx[AW-1:0]] : '0;
   assign resp_write = fcnt_q != '0;
   assign resp_din   = resp_write ? fifo_q[rptr_q] : '0;
   assign pop        = resp_write && resp_full_n;
   assign push       = vld_q[LATENCY-1];

   assign outstanding = out_q;
   assign acc_count   = acc_q;
   assign err_count   = err_q;

   always_comb begin
      vld_d     = '0;
      vld_d[0]  = accept;
      word_d    = word_q;
      word_d[0] = {~in_rng, rd_data, tag};
      for (int i = 1; i < LATENCY; i++) begin
         vld_d[i]  = vld_q[i-1];
         word_d[i] = word_q[i-1];
      end
   end

   // FIFO occupancy is bounded by the credit counter, so push never overflows
   always_comb begin
      fifo_d = fifo_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      fcnt_d = fcnt_q;
      if (push) begin
         fifo_d[wptr_q] = word_q[LATENCY-1];
         wptr_d = (wptr_q == PW'(Q_DEPTH - 1)) ? '0 : wptr_q + PW'(1);
      end
      if (pop) begin
         rptr_d = (rptr_q == PW'(Q_DEPTH - 1)) ? '0 : rptr_q + PW'(1);
      end
      if (push && !pop) begin
         fcnt_d = fcnt_q + OW'(1);
      end else if (pop && !push) begin
         fcnt_d = fcnt_q - OW'(1);
      end
   end

   always_comb begin
      out_d = out_q;
      acc_d = acc_q;
      err_d = err_q;
      if (accept && !pop) begin
         out_d = out_q + OW'(1);
      end else if (pop && !accept) begin
         out_d = out_q - OW'(1);
      end
      if (accept) begin
         acc_d = acc_q + 32'd1;
      end
      if (accept && !in_rng && err_q != 16'hFFFF) begin
         err_d = err_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem_q[wr_addr[AW-1:0]] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      word_q <= word_d;
      fifo_q <= fifo_d;
   end

   always_ff @(posedge clk) begin
      if (!arst_n) begin
         vld_q  <= '0;
         wptr_q <= '0;
         rptr_q <= '0;
         fcnt_q <= '0;
         out_q  <= '0;
         acc_q  <= '0;
         err_q  <= '0;
      end else begin
         vld_q  <= vld_d;
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         fcnt_q <= fcnt_d;
         out_q  <= out_d;
         acc_q  <= acc_d;
         err_q  <= err_d;
      end
   end
endmodule

// File: tb/tb_sim_lat_mem.sv
// Directed bench for sim_lat_mem: latency, ordering, credits, range errors,
// read-before-write and mid-operation reset.
module tb_sim_lat_mem;
   logic        clk = 1'b0;
   logic        arst_n;
   logic        req_empty_n;
   logic        req_read;
   logic [17:0] req_dout;
   logic        resp_full_n;
   logic        resp_write;
   logic [72:0] resp_din;
   logic        wr_en;
   logic [9:0]  wr_addr;
   logic [63:0] wr_data;
   logic [2:0]  outstanding;
   logic [31:0] acc_count;
   logic [15:0] err_count;

   int n_tests = 0;
   int n_fail  = 0;
   int n_acc   = 0;

   logic [17:0] rq[$];
   logic [72:0] eq[$];

   always #5 clk = ~clk;

   sim_lat_mem #(
      .IDX_WIDTH(10), .DEPTH(1000), .DATA_WIDTH(64),
      .TAG_WIDTH(8), .LATENCY(4), .Q_DEPTH(6)
   ) dut (
      .clk(clk), .arst_n(arst_n),
      .req_empty_n(req_empty_n), .req_read(req_read),
      .req_dout(req_dout), .resp_full_n(resp_full_n),
      .resp_write(resp_write), .resp_din(resp_din),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .outstanding(outstanding), .acc_count(acc_count),
      .err_count(err_count)
   );

   function automatic logic [72:0] w(logic e, logic [63:0] d, logic [7:0] t);
      return {e, d, t};
   endfunction

   function automatic logic [17:0] r(int idx, int tag);
      return {10'(idx), 8'(tag)};
   endfunction

   task automatic chk(input string tag, input logic [127:0] got,
                      input logic [127:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // one cycle: check popped head, offer next request, advance
   task automatic cyc();
      logic acc;
      if (resp_write && resp_full_n) begin
         if (eq.size() == 0) chk("spurious_resp", 128'(resp_din), 128'(0));
         else chk("resp", 128'(resp_din), 128'(eq.pop_front()));
      end
      req_empty_n = rq.size() != 0;
      req_dout    = (rq.size() != 0) ? rq[0] : '0;
      acc = req_read && req_empty_n;
      tick();
      if (acc) begin
         void'(rq.pop_front());
         n_acc++;
      end
      req_empty_n = 1'b0;
   endtask

   task automatic preload(input int a, input logic [63:0] d);
      wr_en = 1'b1; wr_addr = 10'(a); wr_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int base;
      logic drop;
      arst_n = 1'b0; req_empty_n = 1'b0; req_dout = '0;
      resp_full_n = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      @(negedge clk);
      tick(); tick();
      chk("rst_req_read", 128'(req_read), 128'(1));
      chk("rst_resp_write", 128'(resp_write), 128'(0));
      chk("rst_resp_din", 128'(resp_din), 128'(0));
      chk("rst_outstanding", 128'(outstanding), 128'(0));
      chk("rst_acc", 128'(acc_count), 128'(0));
      chk("rst_err", 128'(err_count), 128'(0));
      arst_n = 1'b1;

      preload(5, 64'hAB);
      preload(9, 64'hCD);
      preload(0, 64'h55);
      preload(7, 64'h11);
      for (int k = 0; k < 100; k++) preload(100 + k, 64'h1000 + 64'(k * 3));

      // basic latency
      rq.push_back(r(5, 3)); eq.push_back(w(0, 64'hAB, 3));
      rq.push_back(r(9, 4)); eq.push_back(w(0, 64'hCD, 4));
      cyc(); cyc();
      chk("lat_out2", 128'(outstanding), 128'(2));
      chk("lat_empty_e1", 128'(resp_write), 128'(0));
      cyc(); cyc();
      chk("lat_empty_e3", 128'(resp_write), 128'(0));
      cyc();
      chk("lat_valid_e4", 128'(resp_write), 128'(1));
      chk("lat_din_e4", 128'(resp_din), 128'(w(0, 64'hAB, 3)));
      cyc();
      chk("lat_valid_e5", 128'(resp_write), 128'(1));
      cyc();
      chk("lat_drained", 128'(eq.size()), 128'(0));
      chk("lat_acc", 128'(acc_count), 128'(2));
      chk("lat_out0", 128'(outstanding), 128'(0));

      // back-to-back stream
      for (int k = 0; k < 100; k++) begin
         rq.push_back(r(100 + k, k));
         eq.push_back(w(0, 64'h1000 + 64'(k * 3), 8'(k)));
      end
      drop = 1'b0;
      for (int i = 0; i < 110; i++) begin
         if (rq.size() != 0 && !req_read) drop = 1'b1;
         cyc();
      end
      chk("stream_no_drop", 128'(drop), 128'(0));
      chk("stream_all_resp", 128'(eq.size()), 128'(0));
      chk("stream_out0", 128'(outstanding), 128'(0));
      chk("stream_acc", 128'(acc_count), 128'(102));

      // backpressure and credits
      resp_full_n = 1'b0;
      base = n_acc;
      for (int k = 0; k < 10; k++) begin
         rq.push_back(r(100 + k, 8'h80 + k));
         eq.push_back(w(0, 64'h1000 + 64'(k * 3), 8'(8'h80 + k)));
      end
      for (int i = 0; i < 12; i++) cyc();
      chk("bp_accepts", 128'(n_acc - base), 128'(6));
      chk("bp_req_read", 128'(req_read), 128'(0));
      chk("bp_out_full", 128'(outstanding), 128'(6));
      chk("bp_head", 128'(resp_din), 128'(w(0, 64'h1000, 8'h80)));
      resp_full_n = 1'b1;
      cyc();
      chk("bp_credit_back", 128'(req_read), 128'(1));
      chk("bp_out5", 128'(outstanding), 128'(5));
      for (int i = 0; i < 30; i++) cyc();
      chk("bp_all_resp", 128'(eq.size()), 128'(0));
      chk("bp_accepts_all", 128'(n_acc - base), 128'(10));
      chk("bp_out0", 128'(outstanding), 128'(0));

      // out-of-range index
      rq.push_back(r(1010, 8'h21)); eq.push_back(w(1, 64'h0, 8'h21));
      rq.push_back(r(0, 8'h22));    eq.push_back(w(0, 64'h55, 8'h22));
      for (int i = 0; i < 12; i++) cyc();
      chk("oor_resp", 128'(eq.size()), 128'(0));
      chk("oor_err_count", 128'(err_count), 128'(1));

      // read-before-write
      wr_en = 1'b1; wr_addr = 10'd7; wr_data = 64'h22;
      rq.push_back(r(7, 8'h31)); eq.push_back(w(0, 64'h11, 8'h31));
      base = n_acc;
      cyc();
      wr_en = 1'b0;
      chk("rbw_accepted", 128'(n_acc - base), 128'(1));
      rq.push_back(r(7, 8'h32)); eq.push_back(w(0, 64'h22, 8'h32));
      for (int i = 0; i < 12; i++) cyc();
      chk("rbw_resp", 128'(eq.size()), 128'(0));

      // reset with 3 in flight and 2 queued
      resp_full_n = 1'b0;
      for (int k = 0; k < 5; k++) rq.push_back(r(5, 8'h60 + k));
      for (int i = 0; i < 6; i++) cyc();
      chk("mid_out5", 128'(outstanding), 128'(5));
      arst_n = 1'b0;
      wr_en = 1'b1; wr_addr = 10'd5; wr_data = 64'hDEAD;
      tick();
      arst_n = 1'b1; wr_en = 1'b0;
      chk("mid_out0", 128'(outstanding), 128'(0));
      chk("mid_resp_write", 128'(resp_write), 128'(0));
      chk("mid_resp_din", 128'(resp_din), 128'(0));
      chk("mid_acc", 128'(acc_count), 128'(0));
      chk("mid_err", 128'(err_count), 128'(0));
      chk("mid_req_read", 128'(req_read), 128'(1));
      resp_full_n = 1'b1;
      for (int i = 0; i < 10; i++) cyc();
      rq.push_back(r(5, 8'h41)); eq.push_back(w(0, 64'hAB, 8'h41));
      rq.push_back(r(9, 8'h42)); eq.push_back(w(0, 64'hCD, 8'h42));
      for (int i = 0; i < 10; i++) cyc();
      chk("mid_data_intact", 128'(eq.size()), 128'(0));
      chk("mid_acc2", 128'(acc_count), 128'(2));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
